// File: rtl/mmio_io_pkg.sv
// Shared definitions for the board I/O slave: register byte offsets and the
// seven-segment decode used for the six hex digits.
package mmio_io_pkg;

  localparam logic [7:0] IO_SW      = 8'h00;
  localparam logic [7:0] IO_KEYLVL  = 8'h04;
  localparam logic [7:0] IO_KEYEVT  = 8'h08;
  localparam logic [7:0] IO_LED     = 8'h0C;
  localparam logic [7:0] IO_HEX     = 8'h10;
  localparam logic [7:0] IO_BLANK   = 8'h14;
  localparam logic [7:0] IO_IRQMASK = 8'h18;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One board key: 2-flop synchronizer plus a stability counter. level is the
// debounced pressed state; rise pulses in the cycle the level goes 0 -> 1.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed;

  assign pressed = ~sync_q;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    if (pressed == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
      rise    = ~level_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Sync flops reset to "not pressed" so no spurious press follows reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_q    <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= key_n;
      sync_q  <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/mmio_io_port.sv
// Memory-mapped board I/O slave: switches, debounced keys with sticky events,
// LEDs and six seven-segment digits. Define MMIO_IO_IRQ_EN for IRQMASK and irq.
module mmio_io_port
  import mmio_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ADDR_W          = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              io_sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [3:0]        KEY,
  input  logic [9:0]        SW,
  output logic [9:0]        LED,
  output logic [6:0]        SEG0,
  output logic [6:0]        SEG1,
  output logic [6:0]        SEG2,
  output logic [6:0]        SEG3,
  output logic [6:0]        SEG4,
  output logic [6:0]        SEG5,
  output logic              irq
);

  logic [ADDR_W-1:0] a_w;
  logic              wr;
  logic [9:0]        sw_s1_q, sw_s1_d, sw_sync_q, sw_sync_d;
  logic [3:0]        key_lvl, key_rise;
  logic [3:0]        evt_q, evt_d;
  logic [9:0]        led_q, led_d;
  logic [23:0]       hex_q, hex_d;
  logic [5:0]        blank_q, blank_d;
  logic [6:0]        seg [6];
  logic              unused_bits;

  assign a_w         = {addr[ADDR_W-1:2], 2'b00};
  assign wr          = io_sel & we;
  assign unused_bits = ^{wdata[31:24], addr[1:0]};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock  (clock),
      .resetn (resetn),
      .key_n  (KEY[i]),
      .level  (key_lvl[i]),
      .rise   (key_rise[i])
    );
  end

  // A press landing on the same edge as a W1C survives the clear
  always_comb begin
    sw_s1_d   = SW;
    sw_sync_d = sw_s1_q;
    led_d     = (wr && a_w == ADDR_W'(IO_LED))   ? wdata[9:0]  : led_q;
    hex_d     = (wr && a_w == ADDR_W'(IO_HEX))   ? wdata[23:0] : hex_q;
    blank_d   = (wr && a_w == ADDR_W'(IO_BLANK)) ? wdata[5:0]  : blank_q;
    evt_d     = (evt_q & ~((wr && a_w == ADDR_W'(IO_KEYEVT)) ? wdata[3:0] : 4'h0))
              | key_rise;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_s1_q   <= '0;
      sw_sync_q <= '0;
      evt_q     <= '0;
      led_q     <= '0;
      hex_q     <= '0;
      blank_q   <= 6'h3F;
    end else begin
      sw_s1_q   <= sw_s1_d;
      sw_sync_q <= sw_sync_d;
      evt_q     <= evt_d;
      led_q     <= led_d;
      hex_q     <= hex_d;
      blank_q   <= blank_d;
    end
  end

`ifdef MMIO_IO_IRQ_EN
  logic [3:0] irq_mask_q, irq_mask_d;
  logic       irq_q, irq_d;

  always_comb begin
    irq_mask_d = (wr && a_w == ADDR_W'(IO_IRQMASK)) ? wdata[3:0] : irq_mask_q;
    irq_d      = |(evt_q & irq_mask_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (a_w)
      ADDR_W'(IO_SW):      rdata[9:0]  = sw_sync_q;
      ADDR_W'(IO_KEYLVL):  rdata[3:0]  = key_lvl;
      ADDR_W'(IO_KEYEVT):  rdata[3:0]  = evt_q;
      ADDR_W'(IO_LED):     rdata[9:0]  = led_q;
      ADDR_W'(IO_HEX):     rdata[23:0] = hex_q;
      ADDR_W'(IO_BLANK):   rdata[5:0]  = blank_q;
`ifdef MMIO_IO_IRQ_EN
      ADDR_W'(IO_IRQMASK): rdata[3:0]  = irq_mask_q;
`endif
      default:             rdata       = '0;
    endcase
  end

  always_comb begin
    for (int d = 0; d < 6; d++) begin
      seg[d] = blank_q[d] ? SEG_BLANK : hex_to_seg(hex_q[4*d +: 4]);
    end
  end

  assign LED  = led_q;
  assign SEG0 = seg[0];
  assign SEG1 = seg[1];
  assign SEG2 = seg[2];
  assign SEG3 = seg[3];
  assign SEG4 = seg[4];
  assign SEG5 = seg[5];

endmodule

// File: tb/tb_mmio_io_port.sv
// Self-checking bench for mmio_io_port: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the register window.
module tb_mmio_io_port;

  localparam int DEB = 16;
`ifdef MMIO_IO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        io_sel = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = 10'h0;
  logic [9:0]  LED;
  logic [6:0]  seg [6];
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  mmio_io_port #(.DEBOUNCE_CYCLES(DEB), .ADDR_W(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .io_sel (io_sel),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .KEY    (KEY),
    .SW     (SW),
    .LED    (LED),
    .SEG0   (seg[0]),
    .SEG1   (seg[1]),
    .SEG2   (seg[2]),
    .SEG3   (seg[3]),
    .SEG4   (seg[4]),
    .SEG5   (seg[5]),
    .irq    (irq)
  );

  // Reference model: a key level flips once the last DEB synced samples all
  // disagree with it.
  logic [6:0]            seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [9:0]            m_sw1, m_sw;
  logic [3:0]            m_k1, m_k;
  logic [3:0][DEB-1:0]   m_hist, m_hist_n;
  logic [3:0]            m_lvl, m_lvl_n, m_evt, m_mask;
  logic [9:0]            m_led;
  logic [23:0]           m_hex;
  logic [5:0]            m_blank;
  logic                  m_irq;

  always_comb begin
    m_hist_n = '0;
    m_lvl_n  = '0;
    for (int i = 0; i < 4; i++) begin
      m_hist_n[i] = {m_hist[i][DEB-2:0], ~m_k[i]};
      m_lvl_n[i]  = (m_hist_n[i] == {DEB{~m_lvl[i]}}) ? ~m_lvl[i] : m_lvl[i];
    end
  end

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_sw1 <= '0; m_sw <= '0; m_k1 <= 4'hF; m_k <= 4'hF;
      m_hist <= '0; m_lvl <= '0; m_evt <= '0; m_mask <= '0;
      m_led <= '0; m_hex <= '0; m_blank <= 6'h3F; m_irq <= 1'b0;
    end else begin
      m_sw1  <= SW;  m_sw <= m_sw1;
      m_k1   <= KEY; m_k  <= m_k1;
      m_hist <= m_hist_n;
      m_lvl  <= m_lvl_n;
      m_evt  <= (m_evt & ~((io_sel && we && addr[7:2] == 6'd2) ? wdata[3:0] : 4'h0))
              | (m_lvl_n & ~m_lvl);
      m_irq  <= IRQ_ON & (|(m_evt & m_mask));
      if (io_sel && we) begin
        case (addr[7:2])
          6'd3: m_led   <= wdata[9:0];
          6'd4: m_hex   <= wdata[23:0];
          6'd5: m_blank <= wdata[5:0];
          6'd6: if (IRQ_ON) m_mask <= wdata[3:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a[7:2])
      6'd0:    return {22'd0, m_sw};
      6'd1:    return {28'd0, m_lvl};
      6'd2:    return {28'd0, m_evt};
      6'd3:    return {22'd0, m_led};
      6'd4:    return {8'd0, m_hex};
      6'd5:    return {26'd0, m_blank};
      6'd6:    return {28'd0, m_mask};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [6:0] m_seg(input int d);
    logic [3:0] nib;
    nib = m_hex[4*d +: 4];
    return m_blank[d] ? 7'h7F : seg_tbl[nib];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("led", {22'd0, LED}, {22'd0, m_led});
    for (int d = 0; d < 6; d++) chk($sformatf("seg%0d", d), {25'd0, seg[d]}, {25'd0, m_seg(d)});
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("rdata", rdata, m_read(addr));
  endtask

  task automatic cyc();
    @(negedge clock);
    check_all();
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    cyc();
    io_sel = 1'b0; we = 1'b0;
  endtask

  int hold [4] = '{0, 0, 0, 0};

  initial begin
    resetn = 1'b1;
    #2 resetn = 1'b0;
    @(negedge clock);
    check_all();
    chk("rst_led", {22'd0, LED}, 32'd0);
    chk("rst_seg5", {25'd0, seg[5]}, 32'h7F);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_blank", 8'h14, 32'h3F);
    resetn = 1'b1;
    cyc();

    // switch synchronizer latency
    SW = 10'd3;
    cyc(); rd_chk("sw3_e1", 8'h00, 32'd0);
    cyc(); rd_chk("sw3_e2", 8'h00, 32'd3);
    SW = 10'd5;
    cyc(); rd_chk("sw5_e1", 8'h00, 32'd3);
    cyc(); rd_chk("sw5_e2", 8'h00, 32'd5);

    // clean press, W1C, release
    KEY = 4'b1101;
    repeat (20) cyc();
    rd_chk("lvl_k1", 8'h04, 32'h2);
    rd_chk("evt_k1", 8'h08, 32'h2);
    wr(8'h08, 32'h2);
    rd_chk("evt_clr", 8'h08, 32'h0);
    KEY = 4'hF;
    repeat (20) cyc();
    rd_chk("evt_rel", 8'h08, 32'h0);
    rd_chk("lvl_rel", 8'h04, 32'h0);

    // bounce never reaches the stability window
    repeat (4) begin
      KEY[1] = 1'b0;
      repeat (5) begin cyc(); rd_chk("bnc_lvl", 8'h04, 32'h0); end
      KEY[1] = 1'b1;
      cyc(); rd_chk("bnc_evt", 8'h08, 32'h0);
    end
    repeat (4) cyc();

    // display and LEDs
    wr(8'h10, 32'h0000A5);
    wr(8'h14, 32'h3C);
    chk("hex_seg0", {25'd0, seg[0]}, 32'h12);
    chk("hex_seg1", {25'd0, seg[1]}, 32'h08);
    chk("hex_seg2", {25'd0, seg[2]}, 32'h7F);
    chk("hex_seg5", {25'd0, seg[5]}, 32'h7F);
    wr(8'h0C, 32'h3FF);
    chk("led_all", {22'd0, LED}, 32'h3FF);

    // press completes on the same edge as a W1C: set wins
    wr(8'h18, 32'h2);
    wr(8'h08, 32'hF);
    KEY[1] = 1'b0;
    repeat (17) cyc();
    wr(8'h08, 32'hF);
    rd_chk("setwin_evt", 8'h08, 32'h2);
    chk("setwin_irq0", {31'd0, irq}, 32'd0);
    cyc();
    chk("setwin_irq1", {31'd0, irq}, {31'd0, IRQ_ON});
    KEY[1] = 1'b1;
    wr(8'h08, 32'h2);
    chk("irq_hold", {31'd0, irq}, {31'd0, IRQ_ON});
    cyc();
    chk("irq_fall", {31'd0, irq}, 32'd0);
    repeat (20) cyc();

    // reset in the middle of a debounce count
    KEY[2] = 1'b0;
    repeat (8) cyc();
    resetn = 1'b0;
    #1;
    chk("rstmid_seg0", {25'd0, seg[0]}, 32'h7F);
    chk("rstmid_led", {22'd0, LED}, 32'd0);
    rd_chk("rstmid_lvl", 8'h04, 32'h0);
    cyc(); cyc();
    resetn = 1'b1;
    repeat (17) cyc();
    rd_chk("rstmid_evt17", 8'h08, 32'h0);
    cyc();
    rd_chk("rstmid_evt18", 8'h08, 32'h4);
    KEY = 4'hF;
    repeat (20) cyc();

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (hold[k] == 0) begin
          KEY[k]  = 1'($urandom_range(0, 1));
          hold[k] = int'($urandom_range(1, 3 * DEB));
        end else begin
          hold[k]--;
        end
      end
      if ($urandom_range(0, 7) == 0) SW = 10'($urandom);
      io_sel = 1'($urandom_range(0, 1));
      we     = 1'($urandom_range(0, 1));
      addr   = 8'($urandom_range(0, 39));
      wdata  = $urandom;
      if (c == 1200) resetn = 1'b0;
      if (c == 1203) resetn = 1'b1;
      cyc();
    end
    io_sel = 1'b0; we = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
